// File: rtl/somador_pkg.sv
// Shared constants and FSM encoding for the saturating accumulator.
package somador_pkg;
   localparam int DATA_WIDTH     = 9;
   localparam int ACC_WIDTH_DEF  = 12;
   localparam int N_AMOSTRAS_DEF = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } estado_t;
endpackage

// File: rtl/saturador.sv
// Clamps a (W+1)-bit signed sum into W bits and flags the clamp.
module saturador #(
   parameter int W = 12
) (
   input  logic [W:0]   soma_i,
   output logic [W-1:0] valor_o,
   output logic         ovf_o
);
   logic [W-1:0] maximo;
   logic [W-1:0] minimo;

   assign maximo = {1'b0, {(W-1){1'b1}}};
   assign minimo = {1'b1, {(W-1){1'b0}}};

   // Top two bits disagree only when the sum left the W-bit range.
   assign ovf_o   = soma_i[W] ^ soma_i[W-1];
   assign valor_o = ovf_o ? (soma_i[W] ? minimo : maximo)
                          : soma_i[W-1:0];
endmodule

// File: rtl/acumulador_saturado.sv
// Batch accumulator: sums N_AMOSTRAS signed samples with saturation.
module acumulador_saturado
   import somador_pkg::*;
#(
   parameter int N_AMOSTRAS = N_AMOSTRAS_DEF,
   parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  clear,
   output logic [ACC_WIDTH-1:0]  acc_out,
   output logic [3:0]            count,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  saturou
);
   estado_t              estado_q, estado_d;
   logic [ACC_WIDTH-1:0] acc_q, acc_d;
   logic [3:0]           cnt_q, cnt_d;
   logic                 sat_q, sat_d;

   logic [ACC_WIDTH-1:0] base;
   logic [ACC_WIDTH:0]   soma;
   logic [ACC_WIDTH-1:0] sat_val;
   logic                 ovf;
   logic                 ultimo;

   // The first sample of a batch starts from zero regardless of acc_q.
   assign base = (estado_q == ACCUM) ? acc_q : '0;
   assign soma = {{(ACC_WIDTH+1-DATA_WIDTH){data_in[DATA_WIDTH-1]}},
                  data_in}
               + {base[ACC_WIDTH-1], base};
   assign ultimo = (cnt_q == 4'(N_AMOSTRAS - 1));

   saturador #(.W(ACC_WIDTH)) u_sat (
      .soma_i  (soma),
      .valor_o (sat_val),
      .ovf_o   (ovf)
   );

   always_comb begin
      estado_d = estado_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      sat_d    = sat_q;
      unique case (estado_q)
         IDLE: begin
            if (in_valid) begin
               acc_d    = sat_val;
               cnt_d    = 4'd1;
               sat_d    = ovf;
               estado_d = (N_AMOSTRAS == 1) ? DONE : ACCUM;
            end
         end
         ACCUM: begin
            if (in_valid) begin
               acc_d = sat_val;
               cnt_d = cnt_q + 4'd1;
               sat_d = sat_q | ovf;
               if (ultimo) estado_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               estado_d = IDLE;
               acc_d    = '0;
               cnt_d    = '0;
               sat_d    = 1'b0;
            end
         end
         default: begin
            estado_d = IDLE;
            acc_d    = '0;
            cnt_d    = '0;
            sat_d    = 1'b0;
         end
      endcase
      if (clear) begin
         estado_d = IDLE;
         acc_d    = '0;
         cnt_d    = '0;
         sat_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         estado_q <= IDLE;
         acc_q    <= '0;
         cnt_q    <= '0;
         sat_q    <= 1'b0;
      end else begin
         estado_q <= estado_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         sat_q    <= sat_d;
      end
   end

   assign acc_out   = acc_q;
   assign count     = cnt_q;
   assign saturou   = sat_q;
   assign out_valid = (estado_q == DONE);
   assign in_ready  = (estado_q != DONE);
endmodule

// File: tb/tb_acumulador_saturado.sv
// Directed bench: default, 10-bit and single-sample configurations.
module tb_acumulador_saturado;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // u0: defaults
   logic [8:0]  d0;
   logic        v0, clr0, or0, rdy0, ov0, sat0;
   logic [11:0] acc0;
   logic [3:0]  cnt0;
   // u1: ACC_WIDTH=10
   logic [8:0]  d1;
   logic        v1, clr1, or1, rdy1, ov1, sat1;
   logic [9:0]  acc1;
   logic [3:0]  cnt1;
   // u2: N_AMOSTRAS=1
   logic [8:0]  d2;
   logic        v2, clr2, or2, rdy2, ov2, sat2;
   logic [11:0] acc2;
   logic [3:0]  cnt2;

   acumulador_saturado u0 (
      .clk(clk), .rst(rst), .data_in(d0), .in_valid(v0),
      .in_ready(rdy0), .clear(clr0), .acc_out(acc0),
      .count(cnt0), .out_valid(ov0), .out_ready(or0),
      .saturou(sat0)
   );

   acumulador_saturado #(.ACC_WIDTH(10)) u1 (
      .clk(clk), .rst(rst), .data_in(d1), .in_valid(v1),
      .in_ready(rdy1), .clear(clr1), .acc_out(acc1),
      .count(cnt1), .out_valid(ov1), .out_ready(or1),
      .saturou(sat1)
   );

   acumulador_saturado #(.N_AMOSTRAS(1)) u2 (
      .clk(clk), .rst(rst), .data_in(d2), .in_valid(v2),
      .in_ready(rdy2), .clear(clr2), .acc_out(acc2),
      .count(cnt2), .out_valid(ov2), .out_ready(or2),
      .saturou(sat2)
   );

   typedef struct {
      logic        v;
      logic [8:0]  d;
      logic        clr;
      logic        ordy;
      logic [11:0] acc;
      logic [3:0]  cnt;
      logic        ov;
      logic        rdy;
      logic        sat;
   } vec_t;

   vec_t tbl[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string n, input logic [31:0] a,
                      input logic [31:0] e);
      n_cmp++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", n, a, e);
      end
   endtask

   function automatic void add(input logic v, input logic [8:0] d,
                               input logic clr, input logic ordy,
                               input logic [11:0] acc,
                               input logic [3:0] cnt, input logic ov,
                               input logic rdy, input logic sat);
      vec_t r;
      r.v = v; r.d = d; r.clr = clr; r.ordy = ordy;
      r.acc = acc; r.cnt = cnt; r.ov = ov; r.rdy = rdy; r.sat = sat;
      tbl.push_back(r);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv1(input logic v, input logic [8:0] d,
                       input logic clr, input logic ordy);
      v1 = v; d1 = d; clr1 = clr; or1 = ordy;
      tick();
   endtask

   task automatic chk1(input string n, input logic [9:0] acc,
                       input logic [3:0] cnt, input logic ov,
                       input logic sat);
      chk({n, ".acc"}, 32'(acc1), 32'(acc));
      chk({n, ".cnt"}, 32'(cnt1), 32'(cnt));
      chk({n, ".ov"},  32'(ov1),  32'(ov));
      chk({n, ".sat"}, 32'(sat1), 32'(sat));
   endtask

   initial begin
      logic [11:0] e;
      v0 = 0; d0 = '0; clr0 = 0; or0 = 0;
      v1 = 0; d1 = '0; clr1 = 0; or1 = 0;
      v2 = 1; d2 = 9'h007; clr2 = 0; or2 = 0;

      // 8 x +1
      for (int k = 1; k <= 8; k++)
         add(1, 9'h001, 0, 0, 12'(k), 4'(k), k == 8, k != 8, 0);
      add(0, 9'h000, 0, 1, 12'd0, 4'd0, 0, 1, 0);
      // 8 x -1
      for (int k = 1; k <= 8; k++) begin
         e = 12'd0 - 12'(k);
         add(1, 9'h1FF, 0, 0, e, 4'(k), k == 8, k != 8, 0);
      end
      // DONE holds while in_valid is ignored
      for (int k = 0; k < 5; k++)
         add(1, 9'h005, 0, 0, 12'hFF8, 4'd8, 1, 0, 0);
      add(0, 9'h000, 0, 1, 12'd0, 4'd0, 0, 1, 0);
      // clear after 3 samples discards the 4th
      for (int k = 1; k <= 3; k++)
         add(1, 9'h003, 0, 0, 12'(3 * k), 4'(k), 0, 1, 0);
      add(1, 9'h003, 1, 0, 12'd0, 4'd0, 0, 1, 0);
      add(0, 9'h000, 0, 0, 12'd0, 4'd0, 0, 1, 0);
      // clear wins over out_ready in DONE
      for (int k = 1; k <= 8; k++)
         add(1, 9'h002, 0, 0, 12'(2 * k), 4'(k), k == 8, k != 8, 0);
      add(1, 9'h004, 1, 1, 12'd0, 4'd0, 0, 1, 0);

      // reset state (rst held, u2 in_valid high must not be taken)
      tick();
      tick();
      chk("rst.acc", 32'(acc0), 0);
      chk("rst.cnt", 32'(cnt0), 0);
      chk("rst.ov",  32'(ov0),  0);
      chk("rst.rdy", 32'(rdy0), 1);
      chk("rst.sat", 32'(sat0), 0);
      chk("rst.u2cnt", 32'(cnt2), 0);
      rst = 1'b0;

      // N_AMOSTRAS=1 goes straight to DONE
      tick();
      v2 = 0;
      chk("n1.acc", 32'(acc2), 7);
      chk("n1.cnt", 32'(cnt2), 1);
      chk("n1.ov",  32'(ov2),  1);
      chk("n1.rdy", 32'(rdy2), 0);
      or2 = 1;
      tick();
      or2 = 0;
      chk("n1.rel.ov",  32'(ov2),  0);
      chk("n1.rel.acc", 32'(acc2), 0);

      foreach (tbl[i]) begin
         v0 = tbl[i].v; d0 = tbl[i].d;
         clr0 = tbl[i].clr; or0 = tbl[i].ordy;
         tick();
         chk($sformatf("t%0d.acc", i), 32'(acc0), 32'(tbl[i].acc));
         chk($sformatf("t%0d.cnt", i), 32'(cnt0), 32'(tbl[i].cnt));
         chk($sformatf("t%0d.ov", i),  32'(ov0),  32'(tbl[i].ov));
         chk($sformatf("t%0d.rdy", i), 32'(rdy0), 32'(tbl[i].rdy));
         chk($sformatf("t%0d.sat", i), 32'(sat0), 32'(tbl[i].sat));
      end
      v0 = 0; clr0 = 0; or0 = 0;

      // 10-bit: positive clamp, sticky flag, recovery
      drv1(1, 9'h0FF, 0, 0); chk1("w1", 10'd255, 4'd1, 0, 0);
      drv1(1, 9'h0FF, 0, 0); chk1("w2", 10'd510, 4'd2, 0, 0);
      drv1(1, 9'h0FF, 0, 0); chk1("w3", 10'd511, 4'd3, 0, 1);
      drv1(1, 9'h100, 0, 0); chk1("w4", 10'd255, 4'd4, 0, 1);
      for (int k = 5; k <= 8; k++) begin
         drv1(1, 9'h000, 0, 0);
         chk1($sformatf("w%0d", k), 10'd255, 4'(k), k == 8, 1);
      end
      drv1(0, 9'h000, 0, 0); chk1("wdone", 10'd255, 4'd8, 1, 1);

      // asynchronous reset pulse between edges while in DONE
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk1("arst", 10'd0, 4'd0, 0, 0);
      chk("arst.rdy", 32'(rdy1), 1);
      #1 rst = 1'b0;
      tick();
      for (int k = 1; k <= 8; k++) drv1(1, 9'h002, 0, 0);
      chk1("post", 10'd16, 4'd8, 1, 0);
      drv1(0, 9'h000, 0, 1); chk1("postrel", 10'd0, 4'd0, 0, 0);

      // 10-bit: negative clamp, then clear mid-batch
      drv1(1, 9'h100, 0, 0); chk1("n1", 10'h300, 4'd1, 0, 0);
      drv1(1, 9'h100, 0, 0); chk1("n2", 10'h200, 4'd2, 0, 0);
      drv1(1, 9'h100, 0, 0); chk1("n3", 10'h200, 4'd3, 0, 1);
      drv1(1, 9'h001, 1, 0); chk1("nclr", 10'd0, 4'd0, 0, 0);
      drv1(0, 9'h000, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/acumulador_saturado.md
ACUMULADOR_SATURADO -- requirements
Module: acumulador_saturado

Interface
REQ-001 The block SHALL have parameter N_AMOSTRAS, default 8, meaning the number of samples accumulated per result (range 1..15).
REQ-002 The block SHALL have parameter ACC_WIDTH, default 12, meaning the signed accumulator width (range 10..16).
REQ-003 The block SHALL have a single clock and an asynchronous, active-high reset: clk is the single clock and rst is the asynchronous active-high reset.
REQ-004 The block SHALL have the following ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- data_in  input  9  two's-complement registered sum from the upstream registrador.
- in_valid  input  1  data_in is valid this cycle.
- in_ready  output  1  the block accepts a sample this cycle.
- clear  input  1  synchronous abort and clear.
- acc_out  output  ACC_WIDTH  running or final signed accumulation.
- count  output  4  samples accepted in the current batch.
- out_valid  output  1  acc_out holds a completed batch.
- out_ready  input  1  the consumer takes the completed batch.
- saturou  output  1  sticky flag: saturation occurred in the current batch.

Function
REQ-005 The FSM SHALL have states IDLE, ACCUM and DONE; all outputs SHALL be registered or decoded from state only, with no combinational path from inputs to outputs.
REQ-006 A sample SHALL be accepted on a rising clk edge when in_valid=1 and in_ready=1.
REQ-007 in_ready SHALL be 1 in IDLE and ACCUM, and 0 in DONE.
REQ-008 IDLE: on acceptance, acc_out<=sat(data_in) and count<=1; next state SHALL be ACCUM, or DONE if N_AMOSTRAS=1.
REQ-009 ACCUM: on acceptance, acc_out<=sat(acc_out+data_in) and count<=count+1; the state SHALL go to DONE on the edge where count becomes N_AMOSTRAS.
REQ-010 DONE: out_valid=1 and acc_out, count and saturou SHALL be held stable; in_valid SHALL be ignored.
REQ-011 DONE: on out_ready=1, the next state SHALL be IDLE with acc_out=0, count=0 and saturou=0.
REQ-012 Latency: an accepted sample SHALL be visible in acc_out one clk cycle after acceptance.
REQ-013 out_valid SHALL rise in the cycle after the N-th acceptance.
REQ-014 Arithmetic: data_in SHALL be sign-extended to ACC_WIDTH+1 and added to the sign-extended acc_out.
REQ-015 Saturation: a sum greater than 2^(ACC_WIDTH-1)-1 SHALL clamp to that maximum, and a sum less than -2^(ACC_WIDTH-1) SHALL clamp to that minimum.
REQ-016 Any clamp SHALL set saturou=1 on the same edge that updates acc_out.
REQ-017 saturou SHALL remain 1 until the batch is released by out_ready, a clear or a reset.
REQ-018 clear=1 in any state SHALL force IDLE, acc_out=0, count=0 and saturou=0 on the next edge.
REQ-019 A sample presented in the same cycle as clear SHALL be discarded.
REQ-020 If clear and out_ready are both 1 in DONE, clear SHALL take priority; the resulting state is identical (IDLE, cleared).
REQ-021 With in_valid held high in ACCUM, the block SHALL accept one sample per cycle, back to back.
REQ-022 No sample SHALL be lost at the ACCUM->DONE boundary.

Reset
REQ-023 rst=1 SHALL asynchronously force state=IDLE, acc_out=0, count=0, saturou=0 and out_valid=0.
REQ-024 In reset, in_ready SHALL be 1 (IDLE decode); no sample SHALL be accepted while rst=1.
REQ-025 Reset asserted mid-ACCUM or mid-DONE SHALL discard the partial or completed batch with no residual state.
REQ-026 The block SHALL resume operation on the first rising clk edge after rst deasserts.

Structure
REQ-027 Shared package somador_pkg SHALL hold DATA_WIDTH=9, the FSM state encoding (IDLE=2'd0, ACCUM=2'd1, DONE=2'd2) and the default ACC_WIDTH/N_AMOSTRAS constants.
REQ-028 One combinational sub-module, saturador, SHALL take an (ACC_WIDTH+1)-bit sum and return the clamped ACC_WIDTH value plus an overflow flag.
REQ-029 The block SHALL be instantiated downstream of registrador, with data_in taken from its data_out.

Verification
REQ-030 Defaults; 8 back-to-back samples of 9'h001 -> acc_out=12'd8, count=8, out_valid=1 exactly one cycle after the 8th acceptance, saturou=0.
REQ-031 8 samples of 9'h1FF (-1) -> acc_out=12'hFF8 (-8); then out_ready=1 for one cycle -> IDLE with acc_out=0, count=0 and out_valid=0 the next cycle.
REQ-032 ACC_WIDTH=10; samples of 9'h0FF (255) -> acc_out 255, 510, then 511 (clamped) with saturou=1 after the 3rd sample; saturou stays 1 through DONE; a following 9'h100 (-256) gives 255.
REQ-033 In DONE with out_ready=0 for 5 cycles and in_valid=1 with data_in=9'h005 -> in_ready=0, acc_out and count unchanged, no acceptance; out_ready=1 then releases the batch.
REQ-034 clear=1 after 3 accepted samples, in the same cycle as in_valid=1 -> the next cycle shows IDLE, acc_out=0, count=0, and that sample is not counted.
REQ-035 rst pulsed asynchronously (between clk edges) while in DONE -> out_valid, acc_out, count and saturou go to 0 immediately; a new batch of 8 x 9'h002 then gives acc_out=16.
